// File: rtl/cav_ctrl_pkg.sv
// Shared types and constants for the Cavium keystream sequencer.
// Sizes describe the CA datapath geometry that the controller sequences.
package cav_ctrl_pkg;

  localparam int CAV_CELLS  = 111;
  localparam int CAV_RULES  = 8;
  localparam int CAV_KEY_W  = 80;
  localparam int CAV_IV_W   = 80;
  localparam int CAV_IDX_W  = 7;
  localparam int CAV_RULE_W = $clog2(CAV_RULES);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SWEEP,
    COMMIT,
    HOLD,
    DRAIN
  } state_t;

endpackage

// File: rtl/cav_sweep_counter.sv
// Cell sweep counter: current cell index, rule select and last-cell flag.
// Holds at the last cell; the controller clears it to start the next round.
module cav_sweep_counter
  import cav_ctrl_pkg::*;
#(
  parameter int CELLS = CAV_CELLS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  enable,
  output logic [CAV_IDX_W-1:0]  cell_idx,
  output logic [CAV_RULE_W-1:0] rule,
  output logic                  last
);

  logic [CAV_IDX_W-1:0] cell_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cell_q <= '0;
    end else if (clear) begin
      cell_q <= '0;
    end else if (enable && !last) begin
      cell_q <= cell_q + CAV_IDX_W'(1);
    end
  end

  assign last     = (cell_q == CAV_IDX_W'(CELLS - 1));
  assign rule     = cell_q[CAV_RULE_W-1:0];
  assign cell_idx = cell_q;

endmodule

// File: rtl/cav_keystream_ctrl.sv
// Keystream sequencer: loads key/IV, sweeps CA rounds, drops warm-up bits
// and packs committed bits LSB-first into words on a valid/ready port.
module cav_keystream_ctrl
  import cav_ctrl_pkg::*;
#(
  parameter int CELLS         = CAV_CELLS,
  parameter int WORD_W        = 32,
  parameter int WARMUP_ROUNDS = 0,
  parameter int LEN_W         = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [CAV_KEY_W-1:0]  load_key,
  input  logic [CAV_IV_W-1:0]   load_iv,
  input  logic [LEN_W-1:0]      load_len,
  input  logic                  abort,
  output logic [CAV_KEY_W-1:0]  dp_key,
  output logic [CAV_IV_W-1:0]   dp_iv,
  output logic                  dp_load,
  output logic                  dp_step,
  output logic [CAV_IDX_W-1:0]  dp_cell_idx,
  output logic [CAV_RULE_W-1:0] dp_rule,
  output logic                  dp_commit,
  input  logic                  dp_ks_bit,
  output logic                  ks_valid,
  input  logic                  ks_ready,
  output logic [WORD_W-1:0]     ks_word,
  output logic                  done,
  output logic                  busy
);

  localparam int          BIT_W    = $clog2(WORD_W);
  localparam logic [15:0] WARM_CNT = 16'(WARMUP_ROUNDS);

  state_t state_q, state_d;

  logic [CAV_KEY_W-1:0] key_q;
  logic [CAV_IV_W-1:0]  iv_q;
  logic [LEN_W-1:0]     words_left_q;
  logic [BIT_W-1:0]     bit_cnt_q;
  logic [15:0]          round_q;
  logic [WORD_W-1:0]    asm_q;
  logic [WORD_W-1:0]    asm_next;
  logic [WORD_W-1:0]    ks_word_q;
  logic                 ks_valid_q;
  logic                 done_q;

  logic last_cell;
  logic handshake;
  logic keep_bit;
  logic word_full;
  logic slot_free;
  logic last_word;

  cav_sweep_counter #(
    .CELLS (CELLS)
  ) u_sweep (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (abort || (state_q != SWEEP)),
    .enable   (state_q == SWEEP),
    .cell_idx (dp_cell_idx),
    .rule     (dp_rule),
    .last     (last_cell)
  );

  assign handshake = (state_q == IDLE) && load_valid && !abort;
  // round_q saturates at WARM_CNT, so equality marks the end of warm-up.
  assign keep_bit  = (round_q == WARM_CNT);
  assign word_full = (state_q == COMMIT) && keep_bit &&
                     (bit_cnt_q == BIT_W'(WORD_W - 1));
  assign slot_free = !ks_valid_q || ks_ready;
  assign last_word = (words_left_q == LEN_W'(1));

  always_comb begin
    asm_next            = asm_q;
    asm_next[bit_cnt_q] = dp_ks_bit;
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path through it can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    dp_load   = 1'b0;
    dp_step   = 1'b0;
    dp_commit = 1'b0;
    case (state_q)
      IDLE: begin
        if (handshake && (load_len != '0)) state_d = LOAD;
      end
      LOAD: begin
        dp_load = 1'b1;
        state_d = SWEEP;
      end
      SWEEP: begin
        dp_step = 1'b1;
        if (last_cell) state_d = COMMIT;
      end
      COMMIT: begin
        dp_commit = 1'b1;
        if (!word_full)     state_d = SWEEP;
        else if (!slot_free) state_d = HOLD;
        else if (last_word)  state_d = DRAIN;
        else                 state_d = SWEEP;
      end
      HOLD: begin
        if (ks_ready) state_d = last_word ? DRAIN : SWEEP;
      end
      DRAIN: begin
        if (ks_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q        <= '0;
      iv_q         <= '0;
      words_left_q <= '0;
      bit_cnt_q    <= '0;
      round_q      <= '0;
      asm_q        <= '0;
      ks_word_q    <= '0;
      ks_valid_q   <= 1'b0;
      done_q       <= 1'b0;
    end else if (abort) begin
      words_left_q <= '0;
      bit_cnt_q    <= '0;
      round_q      <= '0;
      asm_q        <= '0;
      ks_valid_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;

      if (handshake) begin
        key_q        <= load_key;
        iv_q         <= load_iv;
        words_left_q <= load_len;
        round_q      <= '0;
        bit_cnt_q    <= '0;
        asm_q        <= '0;
        done_q       <= (load_len == '0);
      end

      // A word loaded later in this block overrides the drop on acceptance.
      if (ks_valid_q && ks_ready) ks_valid_q <= 1'b0;

      if (state_q == COMMIT) begin
        if (!keep_bit) begin
          round_q <= round_q + 16'd1;
        end else if (!word_full) begin
          asm_q     <= asm_next;
          bit_cnt_q <= bit_cnt_q + BIT_W'(1);
        end else if (slot_free) begin
          ks_word_q    <= asm_next;
          ks_valid_q   <= 1'b1;
          asm_q        <= '0;
          bit_cnt_q    <= '0;
          words_left_q <= (words_left_q != '0) ? words_left_q - LEN_W'(1) : '0;
        end else begin
          asm_q <= asm_next;
        end
      end

      if ((state_q == HOLD) && ks_ready) begin
        ks_word_q    <= asm_q;
        ks_valid_q   <= 1'b1;
        asm_q        <= '0;
        bit_cnt_q    <= '0;
        words_left_q <= (words_left_q != '0) ? words_left_q - LEN_W'(1) : '0;
      end

      if ((state_q == DRAIN) && ks_ready) done_q <= 1'b1;
    end
  end

  assign load_ready = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign dp_key     = key_q;
  assign dp_iv      = iv_q;
  assign ks_word    = ks_word_q;
  assign ks_valid   = ks_valid_q;
  assign done       = done_q;

endmodule

// File: tb/tb_cav_keystream_ctrl.sv
// Self-checking bench for cav_keystream_ctrl: a datapath model feeds round
// bits, and expected words/timing come from the round arithmetic.
module tb_cav_keystream_ctrl;

  localparam int CELLS  = 111;
  localparam int WORD_W = 32;
  localparam int LEN_W  = 16;
  localparam int WARM_B = 2;
  localparam int ROUND  = CELLS + 1;
  localparam int FIRST  = 1 + ROUND * WORD_W;  // handshake edge -> ks_valid seen

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              load_valid, load_ready, abort, dp_load, dp_step, dp_commit;
  logic              dp_ks_bit, ks_valid, ks_ready, done, busy;
  logic [79:0]       load_key, load_iv, dp_key, dp_iv;
  logic [LEN_W-1:0]  load_len;
  logic [6:0]        dp_cell_idx;
  logic [2:0]        dp_rule;
  logic [WORD_W-1:0] ks_word;

  logic              b_load_valid, b_load_ready, b_dp_load, b_dp_step, b_dp_commit;
  logic              b_dp_ks_bit, b_ks_valid, b_ks_ready, b_done, b_busy;
  logic [79:0]       b_load_key, b_load_iv, b_dp_key, b_dp_iv;
  logic [LEN_W-1:0]  b_load_len;
  logic [6:0]        b_dp_cell_idx;
  logic [2:0]        b_dp_rule;
  logic [WORD_W-1:0] b_ks_word;

  cav_keystream_ctrl #(.CELLS(CELLS), .WORD_W(WORD_W), .WARMUP_ROUNDS(0), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
    .load_key(load_key), .load_iv(load_iv), .load_len(load_len), .abort(abort),
    .dp_key(dp_key), .dp_iv(dp_iv), .dp_load(dp_load), .dp_step(dp_step),
    .dp_cell_idx(dp_cell_idx), .dp_rule(dp_rule), .dp_commit(dp_commit),
    .dp_ks_bit(dp_ks_bit), .ks_valid(ks_valid), .ks_ready(ks_ready),
    .ks_word(ks_word), .done(done), .busy(busy)
  );

  cav_keystream_ctrl #(.CELLS(CELLS), .WORD_W(WORD_W), .WARMUP_ROUNDS(WARM_B), .LEN_W(LEN_W)) dut_warm (
    .clk(clk), .rst_n(rst_n), .load_valid(b_load_valid), .load_ready(b_load_ready),
    .load_key(b_load_key), .load_iv(b_load_iv), .load_len(b_load_len), .abort(1'b0),
    .dp_key(b_dp_key), .dp_iv(b_dp_iv), .dp_load(b_dp_load), .dp_step(b_dp_step),
    .dp_cell_idx(b_dp_cell_idx), .dp_rule(b_dp_rule), .dp_commit(b_dp_commit),
    .dp_ks_bit(b_dp_ks_bit), .ks_valid(b_ks_valid), .ks_ready(b_ks_ready),
    .ks_word(b_ks_word), .done(b_done), .busy(b_busy)
  );

  // Datapath model: the round keystream bit is a table lookup by round index.
  bit ks_bits [0:255];
  bit b_bits  [0:255];
  int unsigned cidx, b_cidx;
  int cyc = 0;

  always @(posedge clk or negedge rst_n)
    if (!rst_n)         cidx <= 0;
    else if (dp_load)   cidx <= 0;
    else if (dp_commit) cidx <= cidx + 1;

  always @(posedge clk or negedge rst_n)
    if (!rst_n)           b_cidx <= 0;
    else if (b_dp_load)   b_cidx <= 0;
    else if (b_dp_commit) b_cidx <= b_cidx + 1;

  assign dp_ks_bit   = ks_bits[cidx % 256];
  assign b_dp_ks_bit = b_bits[b_cidx % 256];

  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int load_cyc; int n_load; int first_valid; int done_cyc;
    int n_done; int last_acc; int seq_err; int stab_err;
  } obs_t;
  obs_t obs;
  logic [WORD_W-1:0] got_q [$];

  function automatic logic [WORD_W-1:0] model_a(input int base);
    logic [WORD_W-1:0] w;
    for (int i = 0; i < WORD_W; i++) w[i] = ks_bits[(base + i) % 256];
    return w;
  endfunction

  function automatic logic [WORD_W-1:0] model_b(input int base);
    logic [WORD_W-1:0] w;
    for (int i = 0; i < WORD_W; i++) w[i] = b_bits[(base + i) % 256];
    return w;
  endfunction

  function automatic logic [79:0] rand80();
    return {16'($urandom()), $urandom(), $urandom()};
  endfunction

  task automatic start_load(input logic [79:0] k, input logic [79:0] iv,
                            input int len, output int t_hs);
    @(negedge clk);
    load_key = k; load_iv = iv; load_len = LEN_W'(len); load_valid = 1'b1;
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    t_hs = cyc;
  endtask

  // Observes one transaction from the cycle after the handshake until done.
  task automatic collect(input int ready_pct, input int budget,
                         input int inject, input logic [79:0] inj_key);
    int exp_cell = 0;
    logic prev_hold = 1'b0;
    logic [WORD_W-1:0] prev_word = '0;
    obs = '{-1, 0, -1, -1, 0, -1, 0, 0};
    got_q.delete();
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      load_valid = (c == inject);
      if (c == inject) begin
        load_key = inj_key; load_len = LEN_W'(7);
      end
      if (dp_load) begin obs.n_load++; obs.load_cyc = cyc; end
      if (done) begin obs.n_done++; obs.done_cyc = cyc; end
      if (dp_step) begin
        if (dp_cell_idx !== 7'(exp_cell) || dp_rule !== 3'(exp_cell % 8)) obs.seq_err++;
        exp_cell++;
      end
      if (dp_commit) begin
        if (exp_cell != CELLS) obs.seq_err++;
        exp_cell = 0;
      end
      if (prev_hold && (!ks_valid || ks_word !== prev_word)) obs.stab_err++;
      if (ks_valid && obs.first_valid < 0) obs.first_valid = cyc;
      ks_ready = ($urandom_range(99) < ready_pct);
      if (ks_valid && ks_ready) begin got_q.push_back(ks_word); obs.last_acc = cyc; end
      prev_hold = ks_valid && !ks_ready;
      prev_word = ks_word;
      if (obs.done_cyc >= 0 && cyc >= obs.done_cyc + 2) break;
    end
    load_valid = 1'b0;
    ks_ready = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (ks_valid) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_cell(input int idx, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (dp_step && dp_cell_idx == 7'(idx)) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if ({load_ready, busy, ks_valid, done, dp_load, dp_step, dp_commit} !== 7'b1000000) begin
      n_bad++;
      $display("FAIL reset_flags: got %b expected 1000000",
               {load_ready, busy, ks_valid, done, dp_load, dp_step, dp_commit});
    end
    n_cmp++;
    if (ks_word !== '0 || dp_key !== '0 || dp_cell_idx !== '0) begin
      n_bad++;
      $display("FAIL reset_regs: ks_word %h dp_key %h cell %0d expected all zero",
               ks_word, dp_key, dp_cell_idx);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_zero_len();
    int t;
    start_load(rand80(), rand80(), 0, t);
    @(negedge clk);
    n_cmp++;
    if (!(cyc == t && done === 1'b1 && dp_load === 1'b0 && busy === 1'b0)) begin
      n_bad++;
      $display("FAIL zero_len_done: done %b dp_load %b busy %b at +%0d expected 1 0 0 at +0",
               done, dp_load, busy, cyc - t);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_len_after: done %b busy %b expected 0 0", done, busy);
    end
  endtask

  task automatic test_single_word();
    int t;
    logic [79:0] k = rand80();
    logic [79:0] iv = rand80();
    for (int i = 0; i < 256; i++) ks_bits[i] = i[0];
    start_load(k, iv, 1, t);
    collect(100, FIRST + 20, -1, '0);
    n_cmp++;
    if (obs.n_load != 1 || obs.load_cyc != t) begin
      n_bad++;
      $display("FAIL single_dp_load: count %0d at +%0d expected 1 at +0", obs.n_load, obs.load_cyc - t);
    end
    n_cmp++;
    if (obs.first_valid != t + FIRST) begin
      n_bad++;
      $display("FAIL single_latency: valid at +%0d expected +%0d", obs.first_valid - t, FIRST);
    end
    n_cmp++;
    if (got_q.size() != 1 || got_q[0] !== 32'hAAAAAAAA || got_q[0] !== model_a(0)) begin
      n_bad++;
      $display("FAIL single_word: got %0d words first %h expected 1 word aaaaaaaa",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : '0);
    end
    n_cmp++;
    if (obs.n_done != 1 || obs.done_cyc != obs.last_acc + 1) begin
      n_bad++;
      $display("FAIL single_done: %0d pulses at +%0d after accept expected 1 at +1",
               obs.n_done, obs.done_cyc - obs.last_acc);
    end
    n_cmp++;
    if (obs.seq_err != 0 || dp_key !== k || dp_iv !== iv) begin
      n_bad++;
      $display("FAIL single_seq_key: seq errors %0d key %h iv %h expected 0 %h %h",
               obs.seq_err, dp_key, dp_iv, k, iv);
    end
  endtask

  task automatic test_warmup();
    int t;
    int fv = -1;
    logic [WORD_W-1:0] w = '0;
    bit seen_done = 1'b0;
    for (int i = 0; i < 256; i++) b_bits[i] = (i == WARM_B);
    @(negedge clk);
    b_load_key = rand80(); b_load_iv = rand80(); b_load_len = LEN_W'(1);
    b_load_valid = 1'b1; b_ks_ready = 1'b1;
    @(posedge clk);
    #1;
    b_load_valid = 1'b0;
    t = cyc;
    for (int c = 0; c < FIRST + WARM_B * ROUND + 50; c++) begin
      @(negedge clk);
      if (b_ks_valid) begin fv = cyc; w = b_ks_word; break; end
    end
    n_cmp++;
    if (fv != t + FIRST + WARM_B * ROUND) begin
      n_bad++;
      $display("FAIL warmup_latency: valid at +%0d expected +%0d", fv - t, FIRST + WARM_B * ROUND);
    end
    n_cmp++;
    if (w !== 32'h00000001 || w !== model_b(WARM_B)) begin
      n_bad++;
      $display("FAIL warmup_word: got %h expected 00000001", w);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (b_done) begin seen_done = 1'b1; break; end
    end
    n_cmp++;
    if (!seen_done || b_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL warmup_done: done seen %b busy %b expected 1 0", seen_done, b_busy);
    end
    b_ks_ready = 1'b0;
  endtask

  task automatic test_multi_word_random();
    int t;
    logic [79:0] k1 = rand80();
    logic [79:0] k2 = ~k1;
    for (int i = 0; i < 256; i++) ks_bits[i] = 1'($urandom());
    start_load(k1, rand80(), 2, t);
    collect(60, 2 * FIRST + 400, 30, k2);
    n_cmp++;
    if (got_q.size() != 2 || got_q[0] !== model_a(0) || got_q[1] !== model_a(WORD_W)) begin
      n_bad++;
      $display("FAIL multi_words: got %0d words %h %h expected %h %h", got_q.size(),
               (got_q.size() > 0) ? got_q[0] : '0, (got_q.size() > 1) ? got_q[1] : '0,
               model_a(0), model_a(WORD_W));
    end
    n_cmp++;
    if (dp_key !== k1 || obs.n_load != 1) begin
      n_bad++;
      $display("FAIL ignored_load: dp_key %h loads %0d expected %h 1", dp_key, obs.n_load, k1);
    end
    n_cmp++;
    if (obs.seq_err != 0 || obs.stab_err != 0) begin
      n_bad++;
      $display("FAIL multi_protocol: seq errors %0d stability errors %0d expected 0 0",
               obs.seq_err, obs.stab_err);
    end
    n_cmp++;
    if (obs.n_done != 1 || obs.done_cyc != obs.last_acc + 1) begin
      n_bad++;
      $display("FAIL multi_done: %0d pulses at +%0d after accept expected 1 at +1",
               obs.n_done, obs.done_cyc - obs.last_acc);
    end
  endtask

  task automatic test_backpressure();
    int t;
    bit ok;
    int bad_strobe = 0;
    int stab = 0;
    logic [WORD_W-1:0] w1;
    for (int i = 0; i < 256; i++) ks_bits[i] = 1'($urandom());
    ks_ready = 1'b0;
    start_load(rand80(), rand80(), 2, t);
    wait_valid(FIRST + 20, ok);
    w1 = ks_word;
    n_cmp++;
    if (!ok || w1 !== model_a(0)) begin
      n_bad++;
      $display("FAIL bp_word1: valid %b word %h expected 1 %h", ok, w1, model_a(0));
    end
    for (int c = 0; c < 3800; c++) begin
      @(negedge clk);
      if (c >= 3600 && (dp_step || dp_commit)) bad_strobe++;
      if (!ks_valid || ks_word !== w1) stab++;
    end
    n_cmp++;
    if (bad_strobe != 0 || stab != 0 || cidx != 2 * WORD_W) begin
      n_bad++;
      $display("FAIL bp_hold: strobes %0d unstable %0d commits %0d expected 0 0 %0d",
               bad_strobe, stab, cidx, 2 * WORD_W);
    end
    ks_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (ks_valid !== 1'b1 || ks_word !== model_a(WORD_W) || done !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_word2: valid %b word %h done %b expected 1 %h 0",
               ks_valid, ks_word, done, model_a(WORD_W));
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b1 || ks_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_done: done %b valid %b busy %b expected 1 0 0", done, ks_valid, busy);
    end
    ks_ready = 1'b0;
  endtask

  task automatic test_abort();
    int t;
    bit ok1, ok2;
    int n_done = 0;
    for (int i = 0; i < 256; i++) ks_bits[i] = 1'($urandom());
    ks_ready = 1'b0;
    start_load(rand80(), rand80(), 3, t);
    wait_valid(FIRST + 20, ok1);
    wait_cell(50, 2 * ROUND, ok2);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (!ok1 || !ok2 || busy !== 1'b0 || dp_step !== 1'b0 || ks_valid !== 1'b0 || load_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_state: reached %b%b busy %b step %b valid %b ready %b expected 11 0 0 0 1",
               ok1, ok2, busy, dp_step, ks_valid, load_ready);
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    abort = 1'b1;
    load_len = LEN_W'(1); load_valid = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0; load_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (n_done != 0 || busy !== 1'b0 || dp_load !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_no_done: done pulses %0d busy %b dp_load %b expected 0 0 0",
               n_done, busy, dp_load);
    end
    for (int i = 0; i < 256; i++) ks_bits[i] = 1'($urandom());
    start_load(rand80(), rand80(), 1, t);
    collect(70, 2 * FIRST, -1, '0);
    n_cmp++;
    if (obs.first_valid != t + FIRST || got_q.size() != 1 || got_q[0] !== model_a(0) ||
        obs.n_done != 1 || obs.done_cyc != obs.last_acc + 1) begin
      n_bad++;
      $display("FAIL abort_reload: valid +%0d words %0d word %h dones %0d expected +%0d 1 %h 1",
               obs.first_valid - t, got_q.size(), (got_q.size() > 0) ? got_q[0] : '0,
               obs.n_done, FIRST, model_a(0));
    end
  endtask

  task automatic test_async_reset();
    int t;
    bit ok1, ok2;
    int n_done = 0;
    ks_ready = 1'b0;
    start_load(rand80(), rand80(), 2, t);
    wait_valid(FIRST + 20, ok1);
    wait_cell(40, 2 * ROUND, ok2);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (!ok1 || !ok2 || load_ready !== 1'b1 || busy !== 1'b0 || dp_step !== 1'b0 ||
        ks_valid !== 1'b0 || dp_commit !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: reached %b%b ready %b busy %b step %b valid %b expected 11 1 0 0 0",
               ok1, ok2, load_ready, busy, dp_step, ks_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    n_cmp++;
    if (n_done != 0 || load_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL async_reset_after: done pulses %0d ready %b expected 0 1", n_done, load_ready);
    end
  endtask

  initial begin
    load_valid = 1'b0; abort = 1'b0; ks_ready = 1'b0;
    load_key = '0; load_iv = '0; load_len = '0;
    b_load_valid = 1'b0; b_ks_ready = 1'b0;
    b_load_key = '0; b_load_iv = '0; b_load_len = '0;
    for (int i = 0; i < 256; i++) begin ks_bits[i] = 1'b0; b_bits[i] = 1'b0; end

    test_reset();
    test_zero_len();
    test_single_word();
    test_warmup();
    test_multi_word_random();
    test_backpressure();
    test_abort();
    test_async_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cav_keystream_ctrl.md
Name: cav_keystream_ctrl

Overview:
Sequencer for the Cavium cellular-automaton keystream datapath. It accepts a key/IV load request and drives the datapath through rounds: a 112-cycle rule sweep per round (111 cells, then 1 commit). It discards a programmable number of warm-up bits, then packs keystream bits into words and hands them out on a valid/ready interface. It sits between the host/cipher top level and the CA register datapath; it holds no CA state itself.

Parameters:
- CELLS, 111: cells swept per round (largest register, c); round length is CELLS+1 cycles.
- WORD_W, 32: keystream word width.
- WARMUP_ROUNDS, 0: leading committed bits discarded after each load.
- LEN_W, 16: width of the word-count field.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- load_valid  in  1  load request.
- load_ready  out  1  high only in IDLE.
- load_key  in  80  key, captured on load handshake.
- load_iv  in  80  IV, captured on load handshake.
- load_len  in  LEN_W  words to generate; 0 = accept, pulse done, produce nothing.
- abort  in  1  synchronous cancel.
- dp_key  out  80  registered key to datapath.
- dp_iv  out  80  registered IV to datapath.
- dp_load  out  1  one-cycle pulse: datapath initialises registers from dp_key/dp_iv.
- dp_step  out  1  datapath evaluates cell dp_cell_idx this cycle.
- dp_cell_idx  out  7  current cell, 0..CELLS-1.
- dp_rule  out  3  CA rule select = dp_cell_idx mod 8.
- dp_commit  out  1  one-cycle pulse: datapath shifts round result in.
- dp_ks_bit  in  1  round keystream bit, combinational, valid while dp_commit=1.
- ks_valid  out  1  output word valid.
- ks_ready  in  1  consumer ready.
- ks_word  out  WORD_W  keystream word; first bit in bit 0 (LSB-first).
- done  out  1  one-cycle pulse after the last word is accepted.
- busy  out  1  state != IDLE.

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset state: IDLE; all outputs 0 except load_ready=1; counters and assembly register cleared.
- Reset mid-operation: aborts immediately; no done.
- States and transitions:
  - IDLE: load_ready=1. On handshake at edge T:
    - capture key/iv/len;
    - round=0, bit_cnt=0, words_left=len;
    - go to LOAD.
    - If len==0: pulse done at T+1 and stay IDLE.
  - LOAD (1 cycle): dp_load=1; go to SWEEP with cell=0.
  - SWEEP: dp_step=1, dp_cell_idx=cell, dp_rule=cell[2:0]. cell increments each cycle. At cell==CELLS-1, go to COMMIT.
  - COMMIT (1 cycle): dp_commit=1; sample dp_ks_bit.
    - If round<WARMUP_ROUNDS: discard the bit.
    - Else: shift it into the assembly register at position bit_cnt and increment bit_cnt.
    - round saturates at WARMUP_ROUNDS.
  - Word completion (bit_cnt reaches WORD_W):
    - If ks_valid==0, or ks_ready==1 this cycle: move the word to ks_word, set ks_valid, decrement words_left, bit_cnt=0.
    - Otherwise go to HOLD.
    - If words_left would hit 0: stop producing, go to DRAIN.
    - Else: next state SWEEP with cell=0.
  - HOLD: dp_step=0. On ks_ready: the assembled word replaces ks_word the next cycle (ks_valid stays 1), then SWEEP or DRAIN.
  - DRAIN: wait for ks_ready on the final word; then ks_valid=0, done=1 for one cycle, go to IDLE.
- Output handshake: ks_word stable while ks_valid && !ks_ready. ks_valid falls the cycle after acceptance unless a new word is loaded in the same edge.
- Round timing: rounds are exactly CELLS+1 = 112 cycles with no bubbles unless in HOLD.
  - Load accepted at edge T: commit r occurs at cycle T+2+112r+111.
  - First word (WARMUP=0, W=32): ks_valid rises at T+3586.
- abort: priority over everything except reset. Next state IDLE; dp_* strobes and ks_valid cleared; no done.
- Simultaneous abort and load_valid in IDLE: abort wins, load not accepted.
- load_valid outside IDLE: ignored; must not disturb operation.
- Counters: cell wraps CELLS-1 to 0 only via COMMIT. words_left never underflows.

Decomposition:
- Package cav_ctrl_pkg:
  - state enum (IDLE, LOAD, SWEEP, COMMIT, HOLD, DRAIN);
  - CAV_CELLS=111, CAV_RULES=8, CAV_KEY_W=80, CAV_IV_W=80.
- Sub-module cav_sweep_counter: cell index, rule select and last-cell flag, with clear/enable.

Test Plan:
- Reset: assert rst_n=0 mid-SWEEP at cell 40 -> all strobes 0, ks_valid=0, load_ready=1 immediately (asynchronous); no done.
- Single word (WARMUP=0, len=1, ks_ready=1):
  - datapath model returns round[0];
  - ks_word=32'hAAAAAAAA, ks_valid at T+3586, done one cycle after acceptance;
  - dp_rule seq 0..7 repeating, dp_cell_idx 0..110.
- Warm-up (WARMUP_ROUNDS=2): model returns 1 only at round 2 -> ks_word=32'h00000001.
- Backpressure (len=2, ks_ready=0):
  - word 1 valid, word 2 completes -> HOLD, dp_step=0 and no dp_commit for the whole hold;
  - raise ks_ready -> word 2 appears next cycle, then done after its acceptance.
- Abort at SWEEP cell 50 -> next cycle IDLE, dp_step=0, ks_valid=0, no done; fresh load then runs normally.
- load_valid pulsed during SWEEP with different key -> ignored, dp_key unchanged. len=0 -> done at T+1, no dp_load.
